address_generator: RTL and testbench

Registered memory-address source for the RISC-SPM datapath, generalising the plain address register. It holds the current memory address and updates it from Bus_2 or under its own arithmetic: load, auto-increment by a fixed step, signed-relative offset, and call/return through a small internal return-address LIFO. The controller selects one operation per cycle, and the output drives the memory address bus directly.

---
 rtl/addr_gen_pkg.sv | 18 +
 rtl/addr_stack.sv | 60 ++++++
 rtl/address_generator.sv | 124 ++++++++++++
 tb/tb_address_generator.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/addr_gen_pkg.sv
// Shared definitions for the address generator: op-code encoding and widths.
// Build option: define ADDR_GEN_STACK_EN to enable CALL/RET with the return-address LIFO.
package addr_gen_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_HOLD    = 3'd0,
        OP_LOAD    = 3'd1,
        OP_INC     = 3'd2,
        OP_REL     = 3'd3,
        OP_CALL    = 3'd4,
        OP_RET     = 3'd5,
        OP_CLR_ERR = 3'd6,
        OP_RSVD    = 3'd7
    } addr_op_t;

endpackage

// File: rtl/addr_stack.sv
// Return-address LIFO: drops a push when full, ignores a pop when empty.
// Error reporting is left to the parent.
module addr_stack #(
    parameter int unsigned word_size   = 8,
    parameter int unsigned stack_depth = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   push_i,
    input  logic                                   pop_i,
    input  logic [word_size-1:0]                   push_data_i,
    output logic [word_size-1:0]                   top_o,
    output logic [$clog2(stack_depth+1)-1:0]       level_o,
    output logic                                   full_o,
    output logic                                   empty_o
);

    localparam int unsigned LVL_W = $clog2(stack_depth + 1);
    localparam int unsigned IDX_W = (stack_depth > 1) ? $clog2(stack_depth) : 1;

    logic [word_size-1:0] mem_q [stack_depth];
    logic [LVL_W-1:0]     level_q;
    logic [LVL_W-1:0]     level_d;
    logic                 do_push;
    logic                 do_pop;

    assign full_o  = (level_q == LVL_W'(stack_depth));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o && !push_i;

    assign top_o = empty_o ? '0 : mem_q[IDX_W'(level_q - LVL_W'(1))];

    always_comb begin
        level_d = level_q;
        if (do_push) begin
            level_d = level_q + LVL_W'(1);
        end else if (do_pop) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    // Contents need no reset; only entries below the level are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[IDX_W'(level_q)] <= push_data_i;
        end
    end

endmodule

// File: rtl/address_generator.sv
// Registered memory-address source: load, increment, relative offset, call/return.
// Build option: ADDR_GEN_STACK_EN enables the return-address LIFO and error flag.
module address_generator
    import addr_gen_pkg::*;
#(
    parameter int unsigned word_size   = 8,
    parameter int unsigned step        = 1,
    parameter int unsigned stack_depth = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [word_size-1:0] data_in,
    input  logic [OP_W-1:0]      op,
    output logic [word_size-1:0] data_out,
    output logic                 stack_empty,
    output logic                 stack_full,
    output logic                 stack_err
);

    localparam logic [word_size-1:0] STEP_W = word_size'(step);

    logic [word_size-1:0] addr_q;
    logic [word_size-1:0] addr_d;
    logic [word_size-1:0] inc_sum;
    logic [word_size-1:0] rel_sum;
    addr_op_t             op_e;

    assign op_e    = addr_op_t'(op);
    assign inc_sum = addr_q + STEP_W;
    // Two's-complement offset: plain modular addition gives the signed result.
    assign rel_sum = addr_q + data_in;

    assign data_out = addr_q;

`ifdef ADDR_GEN_STACK_EN
    localparam int unsigned LVL_W = $clog2(stack_depth + 1);

    logic                 err_q;
    logic                 err_d;
    logic                 push;
    logic                 pop;
    logic [word_size-1:0] stk_top;
    logic [LVL_W-1:0]     stk_level;
    logic                 stk_full;
    logic                 stk_empty;

    addr_stack #(
        .word_size   (word_size),
        .stack_depth (stack_depth)
    ) u_stack (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (inc_sum),
        .top_o       (stk_top),
        .level_o     (stk_level),
        .full_o      (stk_full),
        .empty_o     (stk_empty)
    );

    assign stack_empty = (stk_level == '0);
    assign stack_full  = (stk_level == LVL_W'(stack_depth));
    assign stack_err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    // Depth is required to be at least 1, so this is a constant 1.
    assign stack_empty = (stack_depth != 0);
    assign stack_full  = 1'b0;
    assign stack_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    // Op decode: next address plus stack requests and error update.
    always_comb begin
        addr_d = addr_q;
`ifdef ADDR_GEN_STACK_EN
        err_d  = err_q;
        push   = 1'b0;
        pop    = 1'b0;
`endif
        case (op_e)
            OP_LOAD: addr_d = data_in;
            OP_INC:  addr_d = inc_sum;
            OP_REL:  addr_d = rel_sum;
`ifdef ADDR_GEN_STACK_EN
            OP_CALL: begin
                addr_d = data_in;
                push   = 1'b1;
                if (stk_full) begin
                    err_d = 1'b1;
                end
            end
            OP_RET: begin
                if (stk_empty) begin
                    err_d = 1'b1;
                end else begin
                    addr_d = stk_top;
                    pop    = 1'b1;
                end
            end
            OP_CLR_ERR: err_d = 1'b0;
`else
            OP_CALL: addr_d = data_in;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_address_generator.sv
// Self-checking bench for address_generator: directed test-plan steps then
// randomized ops, all checked against a queue-based reference model.
module tb_address_generator;

    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned STEP  = 1;
`ifdef ADDR_GEN_STACK_EN
    localparam bit STK_EN = 1'b1;
`else
    localparam bit STK_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] data_in;
    logic [2:0]   op;
    logic [W-1:0] data_out;
    logic         stack_empty;
    logic         stack_full;
    logic         stack_err;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_addr;
    int m_stk[$];
    bit m_err;

    address_generator #(
        .word_size   (W),
        .step        (STEP),
        .stack_depth (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .op          (op),
        .data_out    (data_out),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".addr"},  int'(data_out),    m_addr);
        chk({tag, ".empty"}, int'(stack_empty), STK_EN ? int'(m_stk.size() == 0) : 1);
        chk({tag, ".full"},  int'(stack_full),  STK_EN ? int'(m_stk.size() == DEPTH) : 0);
        chk({tag, ".err"},   int'(stack_err),   STK_EN ? int'(m_err) : 0);
    endtask

    function automatic void model_op(input int o, input int d);
        int mask = (1 << W) - 1;
        int sd;
        case (o)
            1: m_addr = d;
            2: m_addr = (m_addr + STEP) & mask;
            3: begin
                sd = (d >= (1 << (W - 1))) ? d - (1 << W) : d;
                m_addr = (m_addr + sd) & mask;
            end
            4: begin
                if (STK_EN) begin
                    if (m_stk.size() < DEPTH) m_stk.push_back((m_addr + STEP) & mask);
                    else m_err = 1'b1;
                end
                m_addr = d;
            end
            5: begin
                if (STK_EN) begin
                    if (m_stk.size() == 0) m_err = 1'b1;
                    else m_addr = m_stk.pop_back();
                end
            end
            6: if (STK_EN) m_err = 1'b0;
            default: ;
        endcase
    endfunction

    task automatic do_op(input string tag, input int o, input int d);
        op      = 3'(o);
        data_in = W'(d);
        @(posedge clk);
        #1;
        model_op(o, d);
        check_all(tag);
    endtask

    task automatic do_reset(input string tag, input int o, input int d);
        rst     = 1'b1;
        op      = 3'(o);
        data_in = W'(d);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_addr = 0;
        m_stk.delete();
        m_err = 1'b0;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b0;
        op = 3'd0;
        data_in = '0;
        m_addr = 0;
        m_err = 1'b0;

        do_reset("reset", 0, 0);
        do_op("hold", 0, 8'h5A);

        // Wrap and signed offset
        do_op("load_fe", 1, 8'hFE);
        do_op("inc_ff", 2, 0);
        chk("inc_ff.lit", int'(data_out), 8'hFF);
        do_op("inc_00", 2, 0);
        chk("inc_00.lit", int'(data_out), 8'h00);
        do_op("load_10", 1, 8'h10);
        do_op("rel_f0", 3, 8'hF0);
        chk("rel_f0.lit", int'(data_out), 8'h00);
        do_op("load_02", 1, 8'h02);
        do_op("rel_fd", 3, 8'hFD);
        chk("rel_fd.lit", int'(data_out), 8'hFF);
        do_op("rsvd", 7, 8'h33);

        // Nested call
        do_op("load_20", 1, 8'h20);
        do_op("call_40", 4, 8'h40);
        do_op("call_60", 4, 8'h60);
        do_op("ret1", 5, 8'hAA);
        if (STK_EN) chk("ret1.lit", int'(data_out), 8'h41);
        do_op("ret2", 5, 8'hAA);
        if (STK_EN) chk("ret2.lit", int'(data_out), 8'h21);

        // Overflow: fifth call loads but is not pushed
        do_op("ov_load", 1, 8'h00);
        for (int i = 0; i < 5; i++) do_op("ov_call", 4, 8'h10 * (i + 1));
        for (int i = 0; i < 4; i++) do_op("ov_ret", 5, 0);

        // Underflow, sticky error, clear
        do_op("un_ret", 5, 8'h77);
        do_op("un_inc", 2, 0);
        do_op("un_clr", 6, 8'h12);

        // Back-to-back call/ret
        do_op("bb_call", 4, 8'h90);
        do_op("bb_ret", 5, 0);

        // Reset overrides a CALL mid-sequence
        do_op("mid_call1", 4, 8'h30);
        do_op("mid_call2", 4, 8'h50);
        do_reset("mid_rst", 4, 8'h70);
        do_op("post_ret", 5, 0);

        // Randomized ops with occasional reset
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 2) do_reset("rnd_rst", int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
            else do_op("rnd", int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
